// File: rtl/rv32i_irq_ctrl.sv
// Interrupt aggregator for rv32i_soc: pending/enable/claim/complete over a small register bus.
// Optional macro IRQ_CTRL_LEVEL_EN adds a MODE register selecting per-source level sensitivity.
module rv32i_irq_ctrl #(
    parameter int unsigned NUM_SRC = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_SRC-1:0] i_src,
    input  logic               i_wr_en,
    input  logic               i_rd_en,
    input  logic [3:0]         i_addr,
    input  logic [31:0]        i_wdata,
    output logic [31:0]        o_rdata,
    output logic               o_ack,
    output logic               o_external_interrupt
);

    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] in_service_q, in_service_d;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] mode;
    logic [31:0]        rdata_q, rdata_d;
    logic               ack_q, ack_d;
    logic               irq_q, irq_d;

    logic [NUM_SRC-1:0] eligible, claim_oh, complete_oh, claim_clr, complete_clr;
    logic [4:0]         claim_id;
    logic               is_rd, do_claim, do_complete;
    logic [1:0]         sel;

`ifdef IRQ_CTRL_LEVEL_EN
    logic [NUM_SRC-1:0] mode_q, mode_d;

    always_comb begin
        mode_d = mode_q;
        if (i_wr_en && sel == 2'd3) begin
            mode_d = i_wdata[NUM_SRC-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode_q <= '0;
        end else begin
            mode_q <= mode_d;
        end
    end

    assign mode = mode_q;
`else
    assign mode = '0;
`endif

    always_comb begin
        sel         = i_addr[3:2];
        // A simultaneous write suppresses the read and its claim side effect.
        is_rd       = i_rd_en & ~i_wr_en;
        do_claim    = is_rd && (sel == 2'd2);
        do_complete = i_wr_en && (sel == 2'd2);
        eligible    = pending_q & enable_q & ~in_service_q;

        claim_id = '0;
        claim_oh = '0;
        for (int unsigned i = NUM_SRC; i > 0; i--) begin
            if (eligible[i-1]) begin
                claim_id = 5'(i);
                claim_oh = '0;
                claim_oh[i-1] = 1'b1;
            end
        end

        complete_oh = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (i_wdata == 32'(i + 1)) begin
                complete_oh[i] = 1'b1;
            end
        end

        claim_clr    = do_claim ? claim_oh : '0;
        complete_clr = do_complete ? complete_oh : '0;
        in_service_d = (in_service_q | claim_clr) & ~complete_clr;

        enable_d = enable_q;
        if (i_wr_en && sel == 2'd1) begin
            enable_d = i_wdata[NUM_SRC-1:0];
        end

        // Edge sources: new edge beats a same-cycle claim. Level sources track the line while idle.
        pending_d = (pending_q & ~claim_clr) | (i_src & ~src_q);
        pending_d = (pending_d & ~mode) | (i_src & ~in_service_d & mode);

        rdata_d = '0;
        if (is_rd) begin
            case (sel)
                2'd0:    rdata_d = 32'(pending_q);
                2'd1:    rdata_d = 32'(enable_q);
                2'd2:    rdata_d = 32'(claim_id);
                default: rdata_d = 32'(mode);
            endcase
        end

        ack_d = i_wr_en | i_rd_en;
        irq_d = |eligible;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending_q    <= '0;
            enable_q     <= '0;
            in_service_q <= '0;
            src_q        <= '0;
            rdata_q      <= '0;
            ack_q        <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            in_service_q <= in_service_d;
            src_q        <= i_src;
            rdata_q      <= rdata_d;
            ack_q        <= ack_d;
            irq_q        <= irq_d;
        end
    end

    assign o_rdata              = rdata_q;
    assign o_ack                = ack_q;
    assign o_external_interrupt = irq_q;

endmodule

// File: tb/tb_rv32i_irq_ctrl.sv
// Self-checking bench for rv32i_irq_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_rv32i_irq_ctrl;

    localparam int unsigned N = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  src;
    logic          wr, rd;
    logic [3:0]    addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ack, irq;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit [N-1:0] m_pend, m_en, m_insvc, m_mode, m_prev;
    bit [31:0]  m_rdata;
    bit         m_ack, m_irq;

    always #5 clk = ~clk;

    rv32i_irq_ctrl #(.NUM_SRC(N)) dut (
        .i_clk(clk), .i_rst(rst), .i_src(src), .i_wr_en(wr), .i_rd_en(rd),
        .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata), .o_ack(ack),
        .o_external_interrupt(irq)
    );

    task automatic model_step();
        int unsigned id;
        bit          irq_next;
        if (rst) begin
            m_pend = 0; m_en = 0; m_insvc = 0; m_mode = 0; m_prev = 0;
            m_rdata = 0; m_ack = 0; m_irq = 0;
            return;
        end
        id = 0;
        irq_next = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (m_pend[k] && m_en[k] && !m_insvc[k]) begin
                id = k + 1;
                irq_next = 1;
            end
        end
        m_ack = wr || rd;
        m_rdata = 0;
        if (wr) begin
            case (addr[3:2])
                2'd1: m_en = wdata[N-1:0];
                2'd2: if (wdata >= 1 && wdata <= N) m_insvc[wdata-1] = 0;
`ifdef IRQ_CTRL_LEVEL_EN
                2'd3: m_mode = wdata[N-1:0];
`endif
                default: ;
            endcase
        end else if (rd) begin
            case (addr[3:2])
                2'd0: m_rdata = 32'(m_pend);
                2'd1: m_rdata = 32'(m_en);
                2'd2: begin
                    m_rdata = id;
                    if (id != 0) begin
                        m_pend[id-1]  = 0;
                        m_insvc[id-1] = 1;
                    end
                end
                default: m_rdata = 32'(m_mode);
            endcase
        end
        for (int k = 0; k < N; k++) begin
            if (m_mode[k]) m_pend[k] = src[k] && !m_insvc[k];
            else if (src[k] && !m_prev[k]) m_pend[k] = 1;
        end
        m_prev = src;
        m_irq = irq_next;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic bus(input bit w, input bit r, input logic [3:0] a, input logic [31:0] d);
        wr = w; rd = r; addr = a; wdata = d;
        tick();
        wr = 0; rd = 0; addr = 0; wdata = 0;
    endtask

    task automatic pulse(input logic [N-1:0] bits);
        src = bits;
        tick();
        src = 0;
    endtask

    task automatic test_reset();
        rst = 1; src = 0; wr = 0; rd = 0; addr = 0; wdata = 0;
        tick(); tick();
        rst = 0;
        checks++;
        if (rdata !== 32'd0 || ack !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got rdata=%0h ack=%0b irq=%0b, expected 0/0/0", rdata, ack, irq);
        end
        bus(0, 1, 4'h4, 0);
        checks++;
        if (rdata !== 32'd0 || ack !== 1'b1) begin
            errors++;
            $display("FAIL reset_enable: got rdata=%0h ack=%0b, expected 0/1", rdata, ack);
        end
    endtask

    task automatic test_single_edge();
        bus(1, 0, 4'h4, 32'h04);
        pulse(8'h04);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL edge_latency1: got irq=%0b expected 0", irq);
        end
        tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL edge_latency2: got irq=%0b expected 1", irq);
        end
        bus(0, 1, 4'h0, 0);
        checks++;
        if (rdata !== 32'h04) begin
            errors++;
            $display("FAIL pending_read: got %0h expected 4", rdata);
        end
        bus(0, 1, 4'h8, 0);
        checks++;
        if (rdata !== 32'd3) begin
            errors++;
            $display("FAIL claim3: got %0d expected 3", rdata);
        end
        bus(0, 1, 4'h0, 0);
        checks++;
        if (rdata !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL after_claim3: got pending=%0h irq=%0b expected 0/0", rdata, irq);
        end
        bus(1, 0, 4'h8, 32'd3);
    endtask

    task automatic test_priority();
        bus(1, 0, 4'h4, 32'hFF);
        pulse(8'h22);
        tick();
        bus(0, 1, 4'h8, 0);
        checks++;
        if (rdata !== 32'd2 || irq !== 1'b1) begin
            errors++;
            $display("FAIL prio_claim1: got id=%0d irq=%0b expected 2/1", rdata, irq);
        end
        bus(0, 1, 4'h8, 0);
        checks++;
        if (rdata !== 32'd6 || irq !== 1'b1) begin
            errors++;
            $display("FAIL prio_claim2: got id=%0d irq=%0b expected 6/1", rdata, irq);
        end
        bus(0, 1, 4'h8, 0);
        checks++;
        if (rdata !== 32'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL prio_claim3: got id=%0d irq=%0b expected 0/0", rdata, irq);
        end
        bus(1, 0, 4'h8, 32'd2);
        bus(1, 0, 4'h8, 32'd6);
    endtask

    task automatic test_in_service();
        pulse(8'h08);
        tick();
        bus(0, 1, 4'h8, 0);
        checks++;
        if (rdata !== 32'd4) begin
            errors++;
            $display("FAIL insvc_claim: got %0d expected 4", rdata);
        end
        pulse(8'h08);
        tick(); tick();
        bus(0, 1, 4'h0, 0);
        checks++;
        if (rdata !== 32'h08 || irq !== 1'b0) begin
            errors++;
            $display("FAIL insvc_hold: got pending=%0h irq=%0b expected 8/0", rdata, irq);
        end
        bus(1, 0, 4'h8, 32'd4);
        tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL complete_raise: got irq=%0b expected 1", irq);
        end
        bus(0, 1, 4'h8, 0);
        checks++;
        if (rdata !== 32'd4) begin
            errors++;
            $display("FAIL reclaim4: got %0d expected 4", rdata);
        end
        bus(1, 0, 4'h8, 32'd4);
    endtask

    task automatic test_bad_complete();
        bus(1, 0, 4'h8, 32'd9);
        checks++;
        if (ack !== 1'b1 || rdata !== 32'd0) begin
            errors++;
            $display("FAIL complete9_ack: got ack=%0b rdata=%0h expected 1/0", ack, rdata);
        end
        bus(1, 0, 4'h8, 32'd0);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL complete0_ack: got ack=%0b expected 1", ack);
        end
        tick();
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL ack_idle: got ack=%0b expected 0", ack);
        end
        bus(0, 1, 4'h4, 0);
        checks++;
        if (rdata !== 32'hFF) begin
            errors++;
            $display("FAIL enable_kept: got %0h expected ff", rdata);
        end
        bus(1, 1, 4'h4, 32'h0F);
        checks++;
        if (rdata !== 32'd0 || ack !== 1'b1) begin
            errors++;
            $display("FAIL wr_rd_both: got rdata=%0h ack=%0b expected 0/1", rdata, ack);
        end
        bus(0, 1, 4'h4, 0);
        checks++;
        if (rdata !== 32'h0F) begin
            errors++;
            $display("FAIL write_wins: got %0h expected f", rdata);
        end
    endtask

    task automatic test_reset_mid_claim();
        pulse(8'h01);
        tick();
        bus(0, 1, 4'h8, 0);
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if (rdata !== 32'd0 || ack !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got rdata=%0h ack=%0b irq=%0b expected 0/0/0", rdata, ack, irq);
        end
        bus(0, 1, 4'h4, 0);
        checks++;
        if (rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_enable: got %0h expected 0", rdata);
        end
    endtask

    task automatic test_mode();
        bit seen;
        bus(1, 0, 4'hC, 32'h01);
        bus(1, 0, 4'h4, 32'h01);
        src = 8'h01;
        tick(); tick();
        bus(0, 1, 4'hC, 0);
`ifdef IRQ_CTRL_LEVEL_EN
        checks++;
        if (rdata !== 32'h01) begin
            errors++;
            $display("FAIL mode_read: got %0h expected 1", rdata);
        end
`else
        checks++;
        if (rdata !== 32'h00) begin
            errors++;
            $display("FAIL mode_read: got %0h expected 0", rdata);
        end
`endif
        bus(0, 1, 4'h8, 0);
        checks++;
        if (rdata !== 32'd1) begin
            errors++;
            $display("FAIL mode_claim: got %0d expected 1", rdata);
        end
        tick(); tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL mode_insvc: got irq=%0b expected 0", irq);
        end
        bus(1, 0, 4'h8, 32'd1);
        seen = 0;
        for (int c = 0; c < 2; c++) begin
            tick();
            if (irq === 1'b1) seen = 1;
        end
`ifdef IRQ_CTRL_LEVEL_EN
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL level_reraise: got irq=0 expected 1 within 2 cycles");
        end
`else
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL edge_once: got irq=1 expected 0");
        end
`endif
        src = 0;
        tick();
        bus(0, 1, 4'h8, 0);
        bus(1, 0, 4'h8, 32'd1);
        bus(1, 0, 4'hC, 32'h0);
    endtask

    task automatic test_random();
        rst = 1;
        tick();
        rst = 0;
        for (int it = 0; it < 600; it++) begin
            int unsigned op;
            src = $urandom_range(0, 7) == 0 ? N'($urandom) : src;
            op = $urandom_range(0, 9);
            wr = (op == 0 || op == 1 || op == 7);
            rd = (op >= 2 && op <= 6) || op == 7;
            addr = 4'($urandom_range(0, 3) << 2) | 4'($urandom_range(0, 3));
            if (op == 1) addr = 4'h8;
            wdata = $urandom_range(0, 1) ? 32'($urandom_range(0, N + 2)) : $urandom;
            rst = ($urandom_range(0, 99) == 0);
            tick();
            checks++;
            if (rdata !== m_rdata || ack !== m_ack || irq !== m_irq) begin
                errors++;
                $display("FAIL random_%0d: got rdata=%0h ack=%0b irq=%0b expected %0h/%0b/%0b",
                         it, rdata, ack, irq, m_rdata, m_ack, m_irq);
            end
        end
        wr = 0; rd = 0; rst = 0; src = 0;
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_priority();
        test_in_service();
        test_bad_complete();
        test_reset_mid_claim();
        test_mode();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv32i_irq_ctrl.md
Name: rv32i_irq_ctrl

Overview:
- Small interrupt aggregator that sits upstream of rv32i_soc.
- Collects up to NUM_SRC raw peripheral interrupt lines, latches them as pending, and masks them with a software-programmed enable register.
- Drives the single `i_external_interrupt` input of the SoC.
- Software uses a memory-mapped claim/complete handshake to learn which source fired and to re-arm it.

Parameters:
- NUM_SRC, 8, number of interrupt source lines (1..31); source IDs are 1..NUM_SRC, and ID 0 means "none".

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, synchronous, active-high
- i_src  in  NUM_SRC  raw interrupt lines, already synchronous to i_clk
- i_wr_en  in  1  register write strobe
- i_rd_en  in  1  register read strobe
- i_addr  in  4  byte address; bits [3:2] select the register
- i_wdata  in  32  write data
- o_rdata  out  32  read data, registered
- o_ack  out  1  access acknowledge, pulses one cycle after the strobe
- o_external_interrupt  out  1  connects to rv32i_soc `i_external_interrupt`

Behaviour:
- Clock and reset:
  - Single clock, i_clk.
  - i_rst is synchronous and active-high; it is sampled only on the rising edge of i_clk.
- Reset values:
  - o_rdata=0, o_ack=0, o_external_interrupt=0.
  - pending=0, enable=0, in_service=0, src_q=0, mode=0.
- Register map:
  - 0x0 PENDING: read-only; bits[NUM_SRC-1:0] = pending.
  - 0x4 ENABLE: read/write mask; bits at or above NUM_SRC read 0.
  - 0x8 CLAIM:
    - Read returns the ID of the highest-priority source that is pending, enabled and not in service.
    - Priority: lowest index wins, so bit0 is ID 1. A read with no such source returns 0.
    - A claim read clears that source's pending bit and sets its in_service bit, both in the same cycle.
  - 0x8 COMPLETE (write):
    - Writing an ID clears in_service[ID-1].
    - IDs 0, IDs > NUM_SRC, and IDs not currently in service are ignored.
  - 0xC MODE: see Optional Feature.
- Bus timing:
  - Strobe sampled at cycle N; o_ack=1 and o_rdata valid at cycle N+1.
  - o_rdata returns to 0 when no read is in progress.
  - If i_wr_en and i_rd_en are asserted together, the write wins and o_rdata=0.
  - A read of an unmapped offset is impossible (4-bit map fully decoded).
- Capture, edge mode:
  - src_q is i_src registered.
  - A rising edge (i_src & ~src_q) sets the pending bit, even while the source is in service.
  - Multiple edges collapse into one pending bit.
- Capture, level mode:
  - pending follows i_src only while in_service=0.
  - While in_service=1, the pending bit is held at 0.
- Set versus clear: if a claim clears a pending bit in the same cycle a new edge sets it, set wins and pending stays 1.
- Interrupt output:
  - o_external_interrupt is registered: |(pending & enable & ~in_service) from the previous cycle.
  - Latency from source edge to output is 2 cycles (edge detect, then output flop).
  - It deasserts the cycle after a claim if no other eligible source remains.
- Disabled sources: clearing an enable bit leaves pending untouched; the source re-raises the output when re-enabled.

Optional Feature:
- Macro: IRQ_CTRL_LEVEL_EN
- Defined:
  - MODE register at 0xC is read/write.
  - Bit k=1 makes source k level-sensitive; bit k=0 makes it edge-sensitive.
- Undefined:
  - All sources are edge-sensitive.
  - 0xC reads 0 and writes to it are ignored; o_ack still pulses.
  - No mode flops are synthesized.

Test Plan:
- Reset, then pulse i_src[2] for one cycle with ENABLE=0x04:
  - o_external_interrupt=1 exactly 2 cycles after the edge.
  - PENDING reads 0x04.
  - CLAIM reads 3, and PENDING then reads 0.
  - The output drops the next cycle.
- Pulse i_src[1] and i_src[5] in the same cycle with ENABLE=0xFF:
  - First CLAIM read returns 2, second returns 6, third returns 0.
  - The output stays 1 until the second claim completes.
- Claim ID 4, then pulse i_src[3] again:
  - PENDING bit3 sets, but the output stays 0 while ID 4 is in service.
  - Write COMPLETE=4; the output rises the next cycle and CLAIM returns 4.
- Write COMPLETE=9 and COMPLETE=0 with nothing in service:
  - No state change; o_ack pulses each time.
- Assert i_rst mid-claim (during the ack cycle):
  - Next cycle all registers are 0, o_ack=0 and o_external_interrupt=0.
- With IRQ_CTRL_LEVEL_EN defined, MODE=0x01, ENABLE=0x01, i_src[0] held high:
  - Claim returns 1.
  - Output remains 0 while in service.
  - COMPLETE=1 with the line still high re-raises the output within 2 cycles.
  - Without the macro, MODE reads 0x0 and a held-high line pends only once.
